// File: rtl/noc_depacketizer_pkg.sv
// Shared NoC receive-side definitions: flit layout, preambles, header descriptor, error codes.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package noc_depacketizer_pkg;

  localparam int noc_flit_size  = 34;
  localparam int yx_width       = 3;
  localparam int msg_type_width = 5;
  localparam int reserved_width = 8;
  localparam int routing_width  = 5;
  localparam int payload_width  = 32;

  // Preamble encodings carried in flit[33:32]
  localparam logic [1:0] preamble_header = 2'b10;
  localparam logic [1:0] preamble_body   = 2'b00;
  localparam logic [1:0] preamble_tail   = 2'b01;
  localparam logic [1:0] preamble_1flit  = 2'b11;

  // Field offsets (LSB position) inside a flit
  localparam int preamble_lsb = 32;
  localparam int src_y_lsb    = 29;
  localparam int src_x_lsb    = 26;
  localparam int dst_y_lsb    = 23;
  localparam int dst_x_lsb    = 20;
  localparam int msg_type_lsb = 15;
  localparam int reserved_lsb = 7;
  localparam int routing_lsb  = 0;

  // Routing bits a flit carries once it has reached its local port
  localparam logic [routing_width-1:0] routing_local = 5'b10000;

  typedef struct packed {
    logic [yx_width-1:0]       src_y;
    logic [yx_width-1:0]       src_x;
    logic [msg_type_width-1:0] msg_type;
    logic [reserved_width-1:0] reserved;
    logic                      single;
  } noc_hdr_t;

  typedef struct packed {
    logic [payload_width-1:0] data;
    logic                     last;
    logic                     err;
  } noc_beat_t;

  typedef enum logic [1:0] {
    ERR_NO_HEADER    = 2'd0,
    ERR_MISSING_TAIL = 2'd1,
    ERR_TOO_LONG     = 2'd2,
    ERR_BAD_DEST     = 2'd3
  } noc_rx_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  // Inverse of create_header: pull the descriptor fields out of a header/single flit.
  function automatic noc_hdr_t parse_header(input logic [noc_flit_size-1:0] flit);
    noc_hdr_t h;
    h.src_y    = flit[src_y_lsb    +: yx_width];
    h.src_x    = flit[src_x_lsb    +: yx_width];
    h.msg_type = flit[msg_type_lsb +: msg_type_width];
    h.reserved = flit[reserved_lsb +: reserved_width];
    h.single   = (flit[preamble_lsb +: 2] == preamble_1flit);
    return h;
  endfunction

endpackage

// File: rtl/noc_out_slice.sv
// One-entry valid/ready output register.
// Latency: 1 cycle from load to out_vld.
// Backpressure: free = !out_vld || out_rdy, so load and drain may share a cycle; data holds while stalled.
//
// Ports: clk/rst (sync, active-high); load/load_dat write the entry (caller must only load when free);
//        out_vld/out_rdy/out_dat are the downstream handshake.
module noc_out_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  output logic         free,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  assign free = !out_vld || out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (load) begin
      out_vld <= 1'b1;
      out_dat <= load_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_depacketizer.sv
// Splits a raw NoC flit stream into header descriptors and 32-bit payload beats, flagging malformed packets.
// Latency: 1 cycle from flit accept to hdr_*/pl_*/err_* outputs.
// Backpressure: in_ready follows the free state of the output slot the current flit targets (header or payload).
//
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready flit input;
//        hdr_valid/hdr_ready/hdr_* header descriptor; pl_valid/pl_ready/pl_data/pl_last/pl_err payload;
//        err_valid/err_code one-cycle error event, err_cnt saturating error count.
// Build option: define NOC_DEPKT_ROUTE_CHECK_EN to reject header/single flits not addressed to (MY_Y, MY_X).
module noc_depacketizer
  import noc_depacketizer_pkg::*;
#(
  parameter logic [yx_width-1:0] MY_Y      = '0,
  parameter logic [yx_width-1:0] MY_X      = '0,
  parameter int                  MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [noc_flit_size-1:0]  in_data,
  output logic                      in_ready,
  output logic                      hdr_valid,
  input  logic                      hdr_ready,
  output logic [yx_width-1:0]       hdr_src_y,
  output logic [yx_width-1:0]       hdr_src_x,
  output logic [msg_type_width-1:0] hdr_msg_type,
  output logic [reserved_width-1:0] hdr_reserved,
  output logic                      hdr_single,
  output logic                      pl_valid,
  input  logic                      pl_ready,
  output logic [payload_width-1:0]  pl_data,
  output logic                      pl_last,
  output logic                      pl_err,
  output logic                      err_valid,
  output logic [1:0]                err_code,
  output logic [15:0]               err_cnt
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  rx_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic        [1:0] pre;
  logic              is_start;
  noc_hdr_t          hdr_in;
  noc_hdr_t          hdr_out;
  noc_beat_t         pl_in;
  noc_beat_t         pl_out;
  logic              hdr_load, hdr_free;
  logic              pl_load, pl_free;
  logic              err_fire;
  noc_rx_err_e       err_code_nxt;
  logic              route_bad;
  logic              unused_bits;

  assign pre      = in_data[preamble_lsb +: 2];
  assign is_start = pre[1];   // header (10) and single (11) both open a packet
  assign hdr_in   = parse_header(in_data);

`ifdef NOC_DEPKT_ROUTE_CHECK_EN
  assign route_bad = (in_data[dst_y_lsb +: yx_width] != MY_Y) ||
                     (in_data[dst_x_lsb +: yx_width] != MY_X) ||
                     (in_data[routing_lsb +: routing_width] != routing_local);
  assign unused_bits = ^in_data[6:5];
`else
  assign route_bad   = 1'b0;
  assign unused_bits = ^{in_data[25:20], in_data[6:0], MY_Y, MY_X};
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    in_ready     = 1'b0;
    hdr_load     = 1'b0;
    pl_load      = 1'b0;
    pl_in        = '0;
    err_fire     = 1'b0;
    err_code_nxt = ERR_NO_HEADER;

    if (!rst) begin
      if (state == ST_BODY) begin
        if (is_start) begin
          // Packet cut short: hold the new flit, close the open payload with a terminator,
          // and let IDLE pick the flit up next cycle.
          if (in_valid && pl_free) begin
            pl_load      = 1'b1;
            pl_in.last   = 1'b1;
            pl_in.err    = 1'b1;
            err_fire     = 1'b1;
            err_code_nxt = ERR_MISSING_TAIL;
            state_nxt    = ST_IDLE;
          end
        end else begin
          in_ready = pl_free;
          if (in_valid && pl_free) begin
            pl_load    = 1'b1;
            pl_in.data = in_data[payload_width-1:0];
            if (pre == preamble_tail) begin
              pl_in.last = 1'b1;
              state_nxt  = ST_IDLE;
            end else if (cnt == CW'(MAX_BEATS - 1)) begin
              // Body flit that fills the last allowed beat: truncate and discard the rest.
              pl_in.last   = 1'b1;
              pl_in.err    = 1'b1;
              err_fire     = 1'b1;
              err_code_nxt = ERR_TOO_LONG;
              state_nxt    = ST_DROP;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
      end else if (state == ST_DROP && !is_start) begin
        in_ready = 1'b1;
        if (in_valid && pre == preamble_tail) begin
          state_nxt = ST_IDLE;
        end
      end else begin
        // IDLE, or DROP seeing a new packet start (handled exactly as IDLE)
        in_ready = hdr_free;
        if (in_valid && hdr_free) begin
          if (is_start) begin
            if (route_bad) begin
              err_fire     = 1'b1;
              err_code_nxt = ERR_BAD_DEST;
              state_nxt    = (pre == preamble_header) ? ST_DROP : ST_IDLE;
            end else begin
              hdr_load = 1'b1;
              if (pre == preamble_header) begin
                state_nxt = ST_BODY;
                cnt_nxt   = '0;
              end else begin
                state_nxt = ST_IDLE;
              end
            end
          end else begin
            err_fire     = 1'b1;
            err_code_nxt = ERR_NO_HEADER;
            state_nxt    = (pre == preamble_body) ? ST_DROP : ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      err_valid <= err_fire;
      if (err_fire) begin
        err_code <= err_code_nxt;
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end

  noc_out_slice #(.W($bits(noc_hdr_t))) u_hdr_slice (
    .clk      (clk),
    .rst      (rst),
    .load     (hdr_load),
    .load_dat (hdr_in),
    .free     (hdr_free),
    .out_vld  (hdr_valid),
    .out_rdy  (hdr_ready),
    .out_dat  (hdr_out)
  );

  noc_out_slice #(.W($bits(noc_beat_t))) u_pl_slice (
    .clk      (clk),
    .rst      (rst),
    .load     (pl_load),
    .load_dat (pl_in),
    .free     (pl_free),
    .out_vld  (pl_valid),
    .out_rdy  (pl_ready),
    .out_dat  (pl_out)
  );

  assign hdr_src_y    = hdr_out.src_y;
  assign hdr_src_x    = hdr_out.src_x;
  assign hdr_msg_type = hdr_out.msg_type;
  assign hdr_reserved = hdr_out.reserved;
  assign hdr_single   = hdr_out.single;
  assign pl_data      = pl_out.data;
  assign pl_last      = pl_out.last;
  assign pl_err       = pl_out.err;

endmodule

// File: tb/tb_noc_depacketizer.sv
// Directed bench for noc_depacketizer (MAX_BEATS=4, tile at (0,0)).
// Latency: n/a. Backpressure: driven through hdr_ready / pl_ready.
module tb_noc_depacketizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [33:0] in_data = '0;
  logic        in_ready;
  logic        hdr_valid, hdr_ready, hdr_single;
  logic [2:0]  hdr_src_y, hdr_src_x;
  logic [4:0]  hdr_msg_type;
  logic [7:0]  hdr_reserved;
  logic        pl_valid, pl_ready, pl_last, pl_err;
  logic [31:0] pl_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] hq[$];
  logic [33:0] pq[$];
  logic [1:0]  eq[$];

  always #5 clk = ~clk;

  noc_depacketizer #(.MY_Y(3'd0), .MY_X(3'd0), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_src_y(hdr_src_y), .hdr_src_x(hdr_src_x),
    .hdr_msg_type(hdr_msg_type), .hdr_reserved(hdr_reserved), .hdr_single(hdr_single),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .pl_last(pl_last), .pl_err(pl_err),
    .err_valid(err_valid), .err_code(err_code), .err_cnt(err_cnt)
  );

  // Record every completed handshake and error pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid && hdr_ready) hq.push_back({hdr_src_y, hdr_src_x, hdr_msg_type, hdr_reserved, hdr_single});
      if (pl_valid && pl_ready)   pq.push_back({pl_data, pl_last, pl_err});
      if (err_valid)              eq.push_back(err_code);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic [1:0] p, input logic [2:0] sy, input logic [2:0] sx,
                                     input logic [2:0] dy, input logic [2:0] dx, input logic [4:0] m,
                                     input logic [7:0] r);
    return {p, sy, sx, dy, dx, m, r, 2'b00, 5'b10000};
  endfunction

  function automatic logic [19:0] hx(input logic [2:0] y, input logic [2:0] x, input logic [4:0] m,
                                     input logic [7:0] r, input logic s);
    return {y, x, m, r, s};
  endfunction

  function automatic logic [33:0] bx(input logic [31:0] d, input logic l, input logic e);
    return {d, l, e};
  endfunction

  function automatic logic [19:0] pop_h();
    if (hq.size() == 0) return '1;
    return hq.pop_front();
  endfunction

  function automatic logic [33:0] pop_p();
    if (pq.size() == 0) return '1;
    return pq.pop_front();
  endfunction

  function automatic logic [1:0] pop_e();
    if (eq.size() == 0) return 2'bxx;
    return eq.pop_front();
  endfunction

  // Present a flit and hold it until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [33:0] f);
    int wait_n;
    wait_n = 0;
    in_valid = 1'b1;
    in_data  = f;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      wait_n++;
      if (wait_n > 40) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    hq.delete();
    pq.delete();
    eq.delete();
  endtask

  int exp_cnt;

  initial begin
    hdr_ready = 1'b1;
    pl_ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {hdr_valid, pl_valid, pl_last, pl_err, hdr_single, err_valid}, 0);
    check("rst_data", {pl_data, hdr_src_y, hdr_src_x, hdr_msg_type, hdr_reserved}, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;

    // 1: plain header / body / tail
    clear_q();
    send(mk(2'b10, 3'd1, 3'd2, 3'd0, 3'd0, 5'h0A, 8'h5A));
    send({2'b00, 32'hDEADBEEF});
    send({2'b01, 32'h12345678});
    idle(4);
    check("t1_hdr_n", hq.size(), 1);
    check("t1_hdr", pop_h(), hx(3'd1, 3'd2, 5'h0A, 8'h5A, 1'b0));
    check("t1_pl_n", pq.size(), 2);
    check("t1_beat0", pop_p(), bx(32'hDEADBEEF, 1'b0, 1'b0));
    check("t1_beat1", pop_p(), bx(32'h12345678, 1'b1, 1'b0));
    check("t1_err_n", eq.size(), 0);

    // 2: single then header/tail back-to-back under header backpressure
    clear_q();
    hdr_ready = 1'b0;
    fork
      begin
        send(mk(2'b11, 3'd2, 3'd5, 3'd0, 3'd0, 5'h03, 8'h00));
        send(mk(2'b10, 3'd3, 3'd4, 3'd0, 3'd0, 5'h11, 8'hC3));
        send({2'b01, 32'hCAFEF00D});
        idle(4);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_hold_vld", hdr_valid, 1);
        check("t2_hold_hdr", {hdr_src_y, hdr_src_x, hdr_msg_type, hdr_single}, {3'd2, 3'd5, 5'h03, 1'b1});
        check("t2_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        hdr_ready = 1'b1;
      end
    join
    check("t2_hdr_n", hq.size(), 2);
    check("t2_hdr0", pop_h(), hx(3'd2, 3'd5, 5'h03, 8'h00, 1'b1));
    check("t2_hdr1", pop_h(), hx(3'd3, 3'd4, 5'h11, 8'hC3, 1'b0));
    check("t2_pl", pop_p(), bx(32'hCAFEF00D, 1'b1, 1'b0));
    check("t2_err_n", eq.size(), 0);

    // 3: body and tail without header
    clear_q();
    send({2'b00, 32'h00001111});
    send({2'b01, 32'h00002222});
    idle(4);
    check("t3_err_n", eq.size(), 1);
    check("t3_err_code", pop_e(), 2'd0);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_no_out", hq.size() + pq.size(), 0);

    // 4: header, body, then a new header before any tail
    clear_q();
    send(mk(2'b10, 3'd1, 3'd1, 3'd0, 3'd0, 5'h07, 8'h01));
    send({2'b00, 32'hAAAA5555});
    send(mk(2'b10, 3'd2, 3'd3, 3'd0, 3'd0, 5'h09, 8'h02));
    send({2'b01, 32'h0BADF00D});
    idle(4);
    check("t4_hdr0", pop_h(), hx(3'd1, 3'd1, 5'h07, 8'h01, 1'b0));
    check("t4_hdr1", pop_h(), hx(3'd2, 3'd3, 5'h09, 8'h02, 1'b0));
    check("t4_beat0", pop_p(), bx(32'hAAAA5555, 1'b0, 1'b0));
    check("t4_term", pop_p(), bx(32'h0, 1'b1, 1'b1));
    check("t4_beat_new", pop_p(), bx(32'h0BADF00D, 1'b1, 1'b0));
    check("t4_err_code", pop_e(), 2'd1);
    check("t4_err_cnt", err_cnt, 2);

    // 5: over-long packet (MAX_BEATS=4), then a clean packet
    clear_q();
    send(mk(2'b10, 3'd4, 3'd0, 3'd0, 3'd0, 5'h1F, 8'hFF));
    for (int i = 0; i < 6; i++) send({2'b00, 32'h100 + 32'(i)});
    send({2'b01, 32'h00000999});
    send(mk(2'b10, 3'd5, 3'd6, 3'd0, 3'd0, 5'h02, 8'h00));
    send({2'b01, 32'h00000777});
    idle(4);
    check("t5_pl_n", pq.size(), 5);
    for (int i = 0; i < 3; i++) check("t5_beat", pop_p(), bx(32'h100 + 32'(i), 1'b0, 1'b0));
    check("t5_beat_trunc", pop_p(), bx(32'h103, 1'b1, 1'b1));
    check("t5_after", pop_p(), bx(32'h777, 1'b1, 1'b0));
    check("t5_hdr_n", hq.size(), 2);
    check("t5_err_code", pop_e(), 2'd2);
    check("t5_err_n", eq.size(), 0);
    check("t5_err_cnt", err_cnt, 3);

    // 6: header addressed to (1,0)
    clear_q();
    send(mk(2'b10, 3'd1, 3'd1, 3'd1, 3'd0, 5'h04, 8'h00));
    send({2'b01, 32'h00000444});
    idle(4);
`ifdef NOC_DEPKT_ROUTE_CHECK_EN
    check("t6_hdr_n", hq.size(), 0);
    check("t6_pl_n", pq.size(), 0);
    check("t6_err_code", pop_e(), 2'd3);
    exp_cnt = 4;
`else
    check("t6_hdr_n", hq.size(), 1);
    check("t6_pl", pop_p(), bx(32'h444, 1'b1, 1'b0));
    check("t6_err_n", eq.size(), 0);
    exp_cnt = 3;
`endif
    check("t6_err_cnt", err_cnt, exp_cnt);

    // 7: reset in the middle of a packet with a stalled payload beat
    pl_ready = 1'b0;
    send(mk(2'b10, 3'd1, 3'd0, 3'd0, 3'd0, 5'h05, 8'h00));
    send({2'b00, 32'h5555AAAA});
    idle(1);
    check("t7_pl_pending", pl_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_in_ready_rst", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_rst_outputs", {hdr_valid, pl_valid, pl_last, pl_err, err_valid}, 0);
    check("t7_rst_data", {pl_data, err_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pl_ready = 1'b1;
    clear_q();
    send({2'b01, 32'h00000001});
    idle(4);
    check("t7_idle_err", pop_e(), 2'd0);
    check("t7_no_term", pq.size(), 0);
    check("t7_err_cnt", err_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
